// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: in-order write-back queue in front of the register file,
// with snooped read-address forwarding from pending entries.
module regfile_wb_buffer #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_addr,
    input  logic [W-1:0]           in_data,
    input  logic                   drain_hold,
    output logic [2:0]             A3,
    output logic [W-1:0]           WD3,
    output logic                   enable,
    input  logic [2:0]             A1,
    input  logic [2:0]             A2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [W-1:0]           fwd1,
    output logic [W-1:0]           fwd2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_r7
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]    r_addr [DEPTH];
    logic [W-1:0]  r_data [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_err;
    logic          w_acc;
    logic          w_push;
    logic          w_pop;

    assign in_ready = r_count < (AW+1)'(DEPTH);
    assign w_acc    = in_valid & in_ready;
    assign w_push   = w_acc & (in_addr != 3'd7);
    assign enable   = (r_count != '0) & ~drain_hold;
    assign w_pop    = enable;
    assign A3       = (r_count != '0) ? r_addr[r_rp] : 3'd0;
    assign WD3      = (r_count != '0) ? r_data[r_rp] : '0;
    assign count    = r_count;
    assign err_r7   = r_err;

    // Scan oldest to youngest so the youngest match wins; the head is included even while popping.
    always_comb begin
        logic [AW-1:0] v_idx;
        v_idx = '0;
        hit1  = 1'b0;
        hit2  = 1'b0;
        fwd1  = '0;
        fwd2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_rp + AW'(i);
            if ((AW+1)'(i) < r_count) begin
                if (r_addr[v_idx] == A1) begin
                    hit1 = 1'b1;
                    fwd1 = r_data[v_idx];
                end
                if (r_addr[v_idx] == A2) begin
                    hit2 = 1'b1;
                    fwd2 = r_data[v_idx];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err   <= w_acc & (in_addr == 3'd7);
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_wp] <= in_addr;
            r_data[r_wp] <= in_data;
        end
    end
endmodule

// File: doc/regfile_wb_buffer.md
REGFILE_WB_BUFFER -- requirements
Module: regfile_wb_buffer

Interface
REQ-001 SHALL have parameter W, default 8: data width, equal to register file width.
REQ-002 SHALL have parameter DEPTH, default 4: write-request queue entries; power of two.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: write request present.
REQ-006 SHALL have port in_ready, output, 1: buffer accepts a request this cycle.
REQ-007 SHALL have port in_addr, input, 3: destination register index.
REQ-008 SHALL have port in_data, input, W: destination data.
REQ-009 SHALL have port drain_hold, input, 1: blocks writes to the register file.
REQ-010 SHALL have port A3, output, 3: register file write address.
REQ-011 SHALL have port WD3, output, W: register file write data.
REQ-012 SHALL have port enable, output, 1: register file write enable.
REQ-013 SHALL have ports A1 and A2, input, 3 each: the register file read addresses, snooped.
REQ-014 SHALL have ports hit1 and hit2, output, 1 each: a pending write matches A1 or A2.
REQ-015 SHALL have ports fwd1 and fwd2, output, W each: forwarded data for A1 and A2.
REQ-016 SHALL have port count, output, log2(DEPTH)+1: occupied entries.
REQ-017 SHALL have port err_r7, output, 1: one-cycle pulse when an address-7 request is discarded.

Function
REQ-018 SHALL hold requests in a FIFO of DEPTH entries {addr, data}; in_ready = (count < DEPTH).
REQ-019 SHALL push on a rising edge when in_valid & in_ready & in_addr != 7.
REQ-020 SHALL accept an address-7 request when in_valid & in_ready, SHALL NOT store it, and SHALL assert err_r7 in the following cycle only, because register 7 is written only via R7.
REQ-021 SHALL combinationally drive enable = (count != 0) & ~drain_hold, with A3/WD3 = head entry while count != 0.
REQ-022 SHALL drive A3 = 0 and WD3 = 0 while count == 0.
REQ-023 SHALL pop the head on every rising edge where enable = 1.
REQ-024 Latency: a request pushed at edge N SHALL be written at edge N+1 at the earliest, with an empty buffer and drain_hold = 0; the buffer SHALL have no bypass path from input to A3/WD3.
REQ-025 Simultaneous push and pop: count SHALL remain unchanged and order SHALL be preserved.
REQ-026 Full: in_ready SHALL be 0 even when a pop occurs in the same cycle; there is no same-cycle full bypass.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-028 hit1 SHALL be 1 when any valid entry has addr == A1; fwd1 SHALL be the data of the youngest matching entry, else 0. hit2 and fwd2 follow the same rule for A2.
REQ-029 Forwarding SHALL include the head entry being popped in the current cycle.
REQ-030 Write order to the register file SHALL equal acceptance order; requests SHALL NOT be merged or dropped, except for address 7.
REQ-031 drain_hold SHALL NOT affect in_ready or forwarding.

Reset
REQ-032 When rst = 0, the block SHALL immediately clear count, pointers, and err_r7, and discard all entries.
REQ-033 During and after reset: in_ready = 1, enable = 0, A3 = 0, WD3 = 0, hit1/hit2 = 0, fwd1/fwd2 = 0.
REQ-034 Reset asserted mid-drain SHALL suppress enable in the same cycle, and no further queued write SHALL reach the register file.

Verification
REQ-035 Empty buffer, push {3, 8'h5A}, drain_hold = 0 -> next cycle enable = 1, A3 = 3, WD3 = 8'h5A; count returns to 0 after the next edge.
REQ-036 drain_hold = 1, push {1,8'h11}, {2,8'h22}, {1,8'h33}, {4,8'h44} -> count = 4, in_ready = 0; A1 = 1 gives hit1 = 1, fwd1 = 8'h33; release hold -> writes 1, 2, 1, 4 in order over 4 cycles.
REQ-037 Full buffer, in_valid held high, hold released -> one pop per cycle; each freed slot is refilled the following cycle and no request is lost.
REQ-038 Push {7, 8'hFF} -> not stored, count unchanged, err_r7 = 1 for exactly one cycle, enable never asserted with A3 = 7.
REQ-039 3 entries queued, rst pulsed low between edges -> enable = 0 immediately, count = 0, no write after release.
REQ-040 Continuous push and pop with count = 2 -> count stays 2 and pointers wrap past DEPTH-1 correctly over 10 cycles.
